// File: rtl/i2s_pattern_checker.sv
// i2s_pattern_checker
// Frame-rate pattern generator and loopback checker for the I2S/TDM audio path.
// Each running frame one deterministic sample per channel is driven towards the
// transmitter. Received frames are compared against the same pattern shifted by
// a latency candidate L. The checker hunts for L, verifies it, reports lock and
// counts mismatching frames while locked.
module i2s_pattern_checker #(
    parameter int SAMPLE_DEPTH = 16,
    parameter int CHANNELS     = 2,
    parameter int MAX_LAT      = 8,
    parameter int LOCK_COUNT   = 4,
    parameter int ERR_WIDTH    = 16
) (
    input  logic                             wclk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [1:0]                       mode,
    input  logic                             err_clear,
    output logic [CHANNELS*SAMPLE_DEPTH-1:0] tx_data,
    output logic                             tx_data_valid,
    input  logic [CHANNELS*SAMPLE_DEPTH-1:0] rx_data,
    input  logic                             rx_data_valid,
    output logic                             locked,
    output logic [$clog2(MAX_LAT+1)-1:0]     latency,
    output logic [ERR_WIDTH-1:0]             err_count,
    output logic                             err_flag
);

    localparam int W  = SAMPLE_DEPTH;
    localparam int C  = CHANNELS;
    localparam int FW = C * W;
    localparam int LW = $clog2(MAX_LAT + 1);
    localparam int CW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // Pattern value for frame n, channel ch. The checkerboard word has every
    // even-numbered bit set (0x5555 for 16 bits) and is used when n[0]^ch[0]=1.
    function automatic logic [W-1:0] pattern_f(input logic [1:0] sel,
                                               input logic [W-1:0] n,
                                               input int ch);
        logic [W-1:0] ramp;
        logic [W-1:0] alt;
        logic         odd;
        ramp = (n * W'(C)) + W'(ch);
        for (int i = 0; i < W; i++) begin
            alt[i] = ((i % 2) == 0) ? 1'b1 : 1'b0;
        end
        odd = n[0] ^ ch[0];
        case (sel)
            2'd1:    pattern_f = ~ramp;
            2'd2:    pattern_f = odd ? alt : ~alt;
            default: pattern_f = ramp;
        endcase
    endfunction

    // Generator state
    logic          run_q;
    logic          run_d;
    logic [1:0]    mode_q;
    logic [1:0]    mode_d;
    logic [W-1:0]  n_q;
    logic [W-1:0]  n_d;
    logic [W-1:0]  tx_index_q;
    logic [W-1:0]  tx_index_d;
    logic [FW-1:0] tx_data_q;
    logic [FW-1:0] tx_data_d;
    logic          tx_valid_q;
    logic          tx_valid_d;

    // Checker state
    state_t                 state_q;
    state_t                 state_d;
    logic [LW-1:0]          lat_q;
    logic [LW-1:0]          lat_d;
    logic [CW-1:0]          match_q;
    logic [CW-1:0]          match_d;
    logic [CW-1:0]          miss_q;
    logic [CW-1:0]          miss_d;
    logic [ERR_WIDTH-1:0]   err_cnt_q;
    logic [ERR_WIDTH-1:0]   err_cnt_d;
    logic                   err_flag_q;
    logic                   err_flag_d;
    logic                   locked_q;
    logic                   locked_d;

    logic [W-1:0]  exp_index_s;
    logic [FW-1:0] exp_data_s;
    logic          frame_match_s;
    logic [LW-1:0] lat_next_s;
    logic [CW-1:0] match_inc_s;
    logic [CW-1:0] miss_inc_s;
    logic          err_hit_s;

    // Run strobe is enable delayed one frame so the mode is latched before the first frame.
    always_comb begin
        run_d  = enable;
        mode_d = mode_q;
        if (enable && !run_q) begin
            mode_d = mode;
        end else begin
            mode_d = mode_q;
        end
    end

    // Generator next state: one pattern frame per running cycle, frame index parked when stopped.
    always_comb begin
        tx_data_d  = tx_data_q;
        tx_index_d = tx_index_q;
        n_d        = n_q;
        tx_valid_d = 1'b0;
        if (run_q) begin
            for (int c = 0; c < C; c++) begin
                tx_data_d[c*W +: W] = pattern_f(mode_q, n_q, c);
            end
            tx_index_d = n_q;
            n_d        = n_q + W'(1);
            tx_valid_d = 1'b1;
        end else begin
            n_d = '0;
        end
    end

    // Expected frame for the current latency candidate and the full-frame compare.
    always_comb begin
        exp_data_s  = '0;
        exp_index_s = tx_index_q - W'(lat_q);
        for (int c = 0; c < C; c++) begin
            exp_data_s[c*W +: W] = pattern_f(mode_q, exp_index_s, c);
        end
    end

    assign frame_match_s = (rx_data == exp_data_s);
    assign lat_next_s    = (lat_q == LW'(MAX_LAT)) ? '0 : lat_q + LW'(1);
    assign match_inc_s   = match_q + CW'(1);
    assign miss_inc_s    = miss_q + CW'(1);
    assign err_hit_s     = run_q && rx_data_valid && (state_q == ST_LOCKED) && !frame_match_s;

    // Lock FSM: hunt for L, confirm it over consecutive frames, drop lock on a run of misses.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        match_d = match_q;
        miss_d  = miss_q;
        if (!run_q) begin
            state_d = ST_IDLE;
            lat_d   = '0;
            match_d = '0;
            miss_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SEARCH;
                    lat_d   = '0;
                    match_d = '0;
                    miss_d  = '0;
                end
                ST_SEARCH: begin
                    if (rx_data_valid && frame_match_s) begin
                        match_d = CW'(1);
                        miss_d  = '0;
                        state_d = (LOCK_COUNT <= 1) ? ST_LOCKED : ST_VERIFY;
                    end else if (rx_data_valid) begin
                        lat_d = lat_next_s;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_VERIFY: begin
                    if (rx_data_valid && frame_match_s) begin
                        match_d = match_inc_s;
                        if (match_inc_s == CW'(LOCK_COUNT)) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                        end else begin
                            state_d = ST_VERIFY;
                        end
                    end else if (rx_data_valid) begin
                        lat_d   = lat_next_s;
                        match_d = '0;
                        state_d = ST_SEARCH;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_LOCKED: begin
                    if (rx_data_valid && !frame_match_s) begin
                        if (miss_inc_s == CW'(LOCK_COUNT)) begin
                            state_d = ST_SEARCH;
                            miss_d  = '0;
                            match_d = '0;
                        end else begin
                            miss_d = miss_inc_s;
                        end
                    end else if (rx_data_valid) begin
                        miss_d = '0;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // Error bookkeeping: clear wins over a same-cycle hit; the count saturates at all-ones.
    always_comb begin
        err_cnt_d  = err_cnt_q;
        err_flag_d = err_flag_q;
        if (err_clear) begin
            err_cnt_d  = '0;
            err_flag_d = 1'b0;
        end else if (err_hit_s) begin
            err_flag_d = 1'b1;
            err_cnt_d  = (err_cnt_q == {ERR_WIDTH{1'b1}}) ? err_cnt_q : err_cnt_q + ERR_WIDTH'(1);
        end else begin
            err_cnt_d  = err_cnt_q;
            err_flag_d = err_flag_q;
        end
    end

    // State registers for generator and checker, synchronous reset has top priority.
    always_ff @(posedge wclk) begin
        if (reset) begin
            run_q      <= 1'b0;
            mode_q     <= 2'd0;
            n_q        <= '0;
            tx_index_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            state_q    <= ST_IDLE;
            lat_q      <= '0;
            match_q    <= '0;
            miss_q     <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            run_q      <= run_d;
            mode_q     <= mode_d;
            n_q        <= n_d;
            tx_index_q <= tx_index_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            state_q    <= state_d;
            lat_q      <= lat_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            err_cnt_q  <= err_cnt_d;
            err_flag_q <= err_flag_d;
            locked_q   <= locked_d;
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_data_valid = tx_valid_q;
    assign locked        = locked_q;
    assign latency       = lat_q;
    assign err_count     = err_cnt_q;
    assign err_flag      = err_flag_q;

endmodule

// File: doc/i2s_pattern_checker.md
# i2s_pattern_checker

Parametrised multi-channel frame-rate pattern generator and loopback checker for the I2S/TDM audio path. Runs on the frame clock `wclk`. Each frame it drives one deterministic sample per channel into the transmitter's parallel sample interface, and compares the receiver's parallel output against the same pattern. It finds the loopback latency in frames on its own, reports lock, and counts sample errors. It replaces ad-hoc ramp stimulus for any `SAMPLE_DEPTH` and channel count.

## Interface
- `SAMPLE_DEPTH`, 16, bits per sample (W); ≥ 8.
- `CHANNELS`, 2, channels per frame (C); ≥ 1.
- `MAX_LAT`, 8, largest latency candidate in frames; `MAX_LAT < 2**SAMPLE_DEPTH`.
- `LOCK_COUNT`, 4, number of consecutive matching frames needed to lock, and consecutive mismatching frames needed to unlock.
- `ERR_WIDTH`, 16, width of the error counter.

Ports:
- `wclk`  in  1  frame clock; all logic is posedge `wclk`.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  run generator and checker.
- `mode`  in  2  pattern select; latched on the `enable` rising edge.
- `err_clear`  in  1  clears `err_count` and `err_flag`.
- `tx_data`  out  C*W  generated samples; channel c occupies bits [c*W +: W].
- `tx_data_valid`  out  1  `tx_data` holds a new frame.
- `rx_data`  in  C*W  received samples, same packing as `tx_data`.
- `rx_data_valid`  in  1  `rx_data` holds a received frame.
- `locked`  out  1  checker locked.
- `latency`  out  clog2(MAX_LAT+1)  current or locked latency candidate L.
- `err_count`  out  ERR_WIDTH  saturating count of mismatched frames while locked.
- `err_flag`  out  1  sticky; set on any mismatch while locked.

## Operation
- Frame index n is a W-bit register, wrapping mod 2**W. P(n,c) is the pattern value for frame n, channel c, computed mod 2**W:
  - mode 0, and mode 3 (treated as mode 0): ramp, (n*C + c). For C=2 this gives L/R = 0/1, 2/3, …
  - mode 1: inverted ramp, ~(n*C + c).
  - mode 2: checkerboard. Value is 0101… if n[0]^c[0] is 1, else 1010…. Its latency is ambiguous mod 2; the checker locks to the smallest L that matches.
- Generator: in every cycle with `enable`=1, `tx_data` is loaded with P(n,·), `tx_index` is set to n, n increments, and `tx_data_valid`=1. When `enable`=0, `tx_data_valid`=0, `tx_data` holds its value, n is cleared to 0, and the mode register holds.
- Checker compare: expected = P(tx_index − L, ·). The compare is combinational against `rx_data` in the same cycle. A frame matches only if all C channels are equal.
- Checker FSM, which advances only in cycles with `rx_data_valid`=1:
  - IDLE: entered on reset or when `enable`=0. Sets L=0 and the match counter to 0. Moves to SEARCH when `enable`=1.
  - SEARCH: on a match, load the match counter with 1 and go to VERIFY. On a mismatch, set L = (L==MAX_LAT) ? 0 : L+1.
  - VERIFY: on a match, increment the match counter; when it reaches LOCK_COUNT, go to LOCKED. On a mismatch, increment L (with the same wrap) and go to SEARCH.
  - LOCKED: on a mismatch, `err_count` increments (saturating at all-ones), `err_flag` sets, and the consecutive-miss counter increments. On a match, the miss counter clears. When the miss counter reaches LOCK_COUNT, go to SEARCH with L unchanged.
- `locked` = 1 exactly while the FSM is in LOCKED, registered.
- `err_clear` takes priority over an increment in the same cycle. Error state is retained when `enable` drops; only `reset` or `err_clear` clears it.

## Timing
- Reset values: `tx_data`=0, `tx_data_valid`=0, `locked`=0, `latency`=0, `err_count`=0, `err_flag`=0. Also n=0, FSM in IDLE, mode register=0.
- `reset` has priority over every other input. Asserting it mid-lock clears everything on the next edge.
- If `enable` is first seen high at edge 0:
  - Edge 1: `tx_data`=P(0), `tx_data_valid`=1, FSM in SEARCH.
  - Edge 1+k: `tx_data`=P(k).
- Lock latency with true latency D and the first valid rx frame at edge 1+D: the FSM tries candidates 0..D over D+1 frames, then needs LOCK_COUNT matches. `locked` rises at edge 1+2D+LOCK_COUNT when the counts start at L=0.
- One L candidate is tested per valid rx frame. A latency greater than MAX_LAT never locks, and L cycles through 0..MAX_LAT indefinitely.
- Frames with `rx_data_valid`=0 change no checker state.

## Test plan
- Direct loopback (`rx`=`tx`, `rx_valid`=`tx_valid`), W=16, C=2, mode 0, enable at edge 0 -> `tx_data` L/R = 0/1, 2/3, 4/5…; `latency`=0; `locked`=1 from edge 5; `err_count`=0.
- 3-frame delay line between tx and rx, mode 0 -> mismatches at edges 4, 5, 6 step L to 3; matches at edges 7–10; `locked`=1 at edge 11; `latency`=3.
- Locked, then flip bit 0 of channel 1 for one frame -> `err_count`=1, `err_flag`=1, `locked` stays 1. Pulse `err_clear` -> `err_count`=0, `err_flag`=0.
- Locked, then force `rx_data`=0 for 4 frames -> `err_count`=4, `locked` falls one edge after the 4th miss. Release -> relock at the same latency after 4 matches.
- ERR_WIDTH=4, 20 consecutive single-frame corruptions separated by good frames -> `err_count` saturates at 15 and never wraps.
- Mode 1 with W=24, C=4, direct loopback -> ch0..3 of frame 0 = FFFFFF, FFFFFE, FFFFFD, FFFFFC; locks at L=0. Assert `reset` mid-lock -> all outputs return to their reset values on the next edge.
